apb_uart_tx_slave: RTL and testbench

//  APB slave sitting directly downstream of the APB bridge master, on the PSEL1 leg (PADDR[32]=0).

---
 rtl/apb_uart_tx_slave.sv | 178 +++++++++++++++++
 tb/tb_apb_uart_tx_slave.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_tx_slave.sv
// APB3 slave with a TX FIFO and an 8N1 UART serialiser driven by a programmable baud divider.
// Define UART_TX_STALL_EN to stall (PREADY=0) on a full-FIFO TXDATA write instead of dropping the byte and setting OVF.
module apb_uart_tx_slave #(
  parameter int FIFO_DEPTH  = 8,
  parameter int BAUDDIV_RST = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [32:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        TX,
  output logic        TX_BUSY
);

  // state | meaning
  // IDLE  | line high, waiting for the FIFO to hold a byte
  // START | start bit (low) for one baud period
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); chains straight into the next frame if bytes remain
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     baud_div, frame_div, baud_cnt;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            ovf, tx_q, tx_cur;
  logic            full, empty, access, full_wr, overflow, wr_en, push, pop, load, baud_tc;
  logic [1:0]      addr;
  logic            unused_bits;

  assign addr    = PADDR[3:2];
  assign access  = PSEL & PENABLE;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign full_wr = access & PWRITE & (addr == 2'b00) & full;

`ifdef UART_TX_STALL_EN
  assign PREADY   = access & ~full_wr;
  assign overflow = 1'b0;
`else
  assign PREADY   = access;
  assign overflow = full_wr;
`endif

  assign PSLVERR = PREADY & ((addr == 2'b11) | overflow);
  assign wr_en   = PREADY & PWRITE;
  assign push    = wr_en & (addr == 2'b00) & ~full;
  assign TX      = tx_q;
  assign TX_BUSY = (state != IDLE) | ~empty;
  assign baud_tc = (baud_cnt == '0);

  assign unused_bits = ^{PADDR[32:4], PADDR[1:0], PWDATA[31:16]};

  always_comb begin
    PRDATA = '0;
    if (access & ~PWRITE) begin
      case (addr)
        2'b01:   PRDATA = {27'b0, TX_BUSY, full, empty, ovf, empty};
        2'b10:   PRDATA = {16'b0, baud_div};
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      baud_div <= 16'(BAUDDIV_RST);
      ovf      <= 1'b0;
    end else begin
      if (wr_en && addr == 2'b10)
        baud_div <= (PWDATA[15:0] == '0) ? 16'd1 : PWDATA[15:0];
      if (wr_en && addr == 2'b01 && PWDATA[0])
        ovf <= 1'b0;
      else if (PREADY && overflow)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PWDATA[7:0];
  end

  // A pop never frees a slot for a push in the same cycle: push looks only at the registered count.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    tx_cur    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_cur = 1'b0;
        if (baud_tc) state_nxt = DATA;
      end
      DATA: begin
        tx_cur = shreg[0];
        if (baud_tc && bit_cnt == 3'd0) state_nxt = STOP;
      end
      STOP: begin
        if (baud_tc) begin
          if (!empty) begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      shreg     <= '0;
      frame_div <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_q <= tx_cur;
      if (load) begin
        shreg     <= mem[rd_ptr];
        frame_div <= baud_div;
        baud_cnt  <= baud_div - 16'd1;
        bit_cnt   <= 3'd7;
      end else if (state != IDLE) begin
        if (baud_tc) begin
          baud_cnt <= frame_div - 16'd1;
          if (state == DATA) begin
            shreg <= {1'b0, shreg[7:1]};
            if (bit_cnt != 3'd0) bit_cnt <= bit_cnt - 3'd1;
          end
        end else begin
          baud_cnt <= baud_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_slave.sv
// Directed bench for apb_uart_tx_slave: APB register checks, cycle-exact frame timing, and a
// scoreboard of queued bytes compared against frames decoded from TX.
module tb_apb_uart_tx_slave;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [32:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, TX, TX_BUSY;

  int   tests = 0;
  int   fails = 0;
  int   baud  = 16;
  int   epoch = 0;
  logic [7:0] exp_q[$];
  logic       busy_en = 1'b0;
  int         busy_cycles = 0;

  apb_uart_tx_slave #(.FIFO_DEPTH(8), .BAUDDIV_RST(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .TX(TX), .TX_BUSY(TX_BUSY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge; the exit edge is the accepting edge.
  task automatic apb(input logic wr, input logic [32:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    check("setup_pready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY === 1'b1 || waits >= 5000) break;
      waits++;
    end
    check("access_timeout", {31'b0, PREADY}, 32'd1);
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (n < bound) begin
      @(negedge PCLK);
      if (TX_BUSY === 1'b0) break;
      n++;
    end
    check("idle_timeout", {31'b0, TX_BUSY}, 32'd0);
    repeat (2 * baud + 4) @(posedge PCLK);
    #1;
  endtask

  always @(negedge PCLK) if (busy_en && TX_BUSY === 1'b1) busy_cycles++;

  // Frame decoder: samples mid-bit, and discards any frame cut short by a reset.
  initial begin
    forever begin
      int b, ep;
      logic [7:0] rx;
      logic st, sp;
      @(negedge TX);
      b = baud; ep = epoch;
      repeat (b / 2) @(posedge PCLK);
      @(negedge PCLK);
      st = TX;
      for (int i = 0; i < 8; i++) begin
        repeat (b) @(posedge PCLK);
        @(negedge PCLK);
        rx[i] = TX;
      end
      repeat (b) @(posedge PCLK);
      @(negedge PCLK);
      sp = TX;
      if (ep == epoch) begin
        check("mon_start", {31'b0, st}, 32'd0);
        check("mon_stop", {31'b0, sp}, 32'd1);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $error("FAIL mon_unexpected: observed 0x%0h expected no frame", rx);
        end else begin
          check("mon_byte", {24'b0, rx}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    logic [7:0]  byte_v;
    logic        exp_tx;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_tx", {31'b0, TX}, 32'd1);
    check("rst_busy", {31'b0, TX_BUSY}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    apb(1'b0, 33'h4, '0, rd, err, w);
    check("status_rst", rd, 32'h5);
    check("status_rst_err", {31'b0, err}, 32'd0);
    apb(1'b0, 33'h8, '0, rd, err, w);
    check("baud_rst", rd, 32'h10);
    apb(1'b0, 33'h0, '0, rd, err, w);
    check("txdata_read", rd, 32'h0);
    check("idle_tx", {31'b0, TX}, 32'd1);

    apb(1'b1, 33'h8, 32'h0, rd, err, w);
    apb(1'b0, 33'h8, '0, rd, err, w);
    check("baud_zero", rd, 32'h1);
    apb(1'b1, 33'hC, 32'hFFFF, rd, err, w);
    check("unmapped_wr_err", {31'b0, err}, 32'd1);
    apb(1'b0, 33'h1_0000_000C, '0, rd, err, w);
    check("unmapped_rd_err", {31'b0, err}, 32'd1);
    check("unmapped_rd_data", rd, 32'h0);
    apb(1'b0, 33'h1_0000_0009, '0, rd, err, w);
    check("baud_after_unmapped", rd, 32'h1);
    apb(1'b1, 33'h8, 32'hABCD_0004, rd, err, w);
    apb(1'b0, 33'h8, '0, rd, err, w);
    check("baud_4", rd, 32'h4);
    baud = 4;

    // Cycle-exact single frame: j counts falling edges after the accepting edge.
    byte_v = 8'hA5;
    apb(1'b1, 33'h0, {24'h0, byte_v}, rd, err, w);
    check("tx_wr_err", {31'b0, err}, 32'd0);
    exp_q.push_back(byte_v);
    for (int j = 0; j < 44; j++) begin
      @(negedge PCLK);
      if (j < 2)       exp_tx = 1'b1;
      else if (j < 6)  exp_tx = 1'b0;
      else if (j < 38) exp_tx = byte_v[(j - 6) / 4];
      else             exp_tx = 1'b1;
      check($sformatf("tx_wave_%0d", j), {31'b0, TX}, {31'b0, exp_tx});
      if (j == 0) check("busy_after_push", {31'b0, TX_BUSY}, 32'd1);
      if (j == 42) check("busy_after_frame", {31'b0, TX_BUSY}, 32'd0);
    end
    wait_idle(200);

    busy_cycles = 0;
    apb(1'b1, 33'h0, 32'h3C, rd, err, w);
    busy_en = 1'b1;
    exp_q.push_back(8'h3C);
    apb(1'b1, 33'h0, 32'hC3, rd, err, w);
    exp_q.push_back(8'hC3);
    apb(1'b1, 33'h0, 32'h5A, rd, err, w);
    exp_q.push_back(8'h5A);
    wait_idle(1000);
    busy_en = 1'b0;
    check("b2b_busy_cycles", busy_cycles, 32'd121);
    check("b2b_drained", exp_q.size(), 32'd0);

    apb(1'b1, 33'h8, 32'd100, rd, err, w);
    baud = 100;
    for (int i = 0; i < 9; i++) begin
      apb(1'b1, 33'h0, 32'h10 + i, rd, err, w);
      check($sformatf("fill_err_%0d", i), {31'b0, err}, 32'd0);
      exp_q.push_back(8'(8'h10 + i));
    end
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("status_full", rd, 32'h18);
`ifdef UART_TX_STALL_EN
    apb(1'b1, 33'h0, 32'hEE, rd, err, w);
    check("stall_err", {31'b0, err}, 32'd0);
    check("stall_waited", {31'b0, (w > 900 && w < 1100)}, 32'd1);
    exp_q.push_back(8'hEE);
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("status_stall", rd, 32'h18);
`else
    apb(1'b1, 33'h0, 32'hEE, rd, err, w);
    check("ovf_err", {31'b0, err}, 32'd1);
    check("ovf_nowait", w, 32'd0);
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("status_ovf", rd, 32'h1A);
    apb(1'b1, 33'h4, 32'h1E, rd, err, w);
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("ovf_sticky", rd, 32'h1A);
    apb(1'b1, 33'h4, 32'h1, rd, err, w);
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("ovf_cleared", rd, 32'h18);
`endif
    wait_idle(12000);
    check("fill_drained", exp_q.size(), 32'd0);

    apb(1'b1, 33'h8, 32'd4, rd, err, w);
    baud = 4;
    apb(1'b1, 33'h0, 32'h00, rd, err, w);
    for (int j = 0; j <= 12; j++) @(negedge PCLK);
    check("mid_data_low", {31'b0, TX}, 32'd0);
    PRESET = 1'b1;
    epoch++;
    #1;
    check("rst_mid_tx", {31'b0, TX}, 32'd1);
    check("rst_mid_busy", {31'b0, TX_BUSY}, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    apb(1'b0, 33'h4, '0, rd, err, w);
    check("status_after_rst", rd, 32'h5);
    apb(1'b0, 33'h8, '0, rd, err, w);
    check("baud_after_rst", rd, 32'h10);
    repeat (60) @(posedge PCLK);
    check("tx_after_rst", {31'b0, TX}, 32'd1);
    check("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
